// File: rtl/led_pattern_gen_if.sv
// Configuration write port of the LED pattern generator.
// The master drives single-cycle channel writes; the generator is the slave.
interface led_pattern_gen_if #(
    parameter int CH_W = 2
) ();
    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [1:0]      cfg_mode;
    logic [7:0]      cfg_param;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_param
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_param
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF, PWM, BLINK and BREATHE per channel.
// One shared prescaler tick and one free-running 8-bit PWM counter.
module led_pattern_gen #(
    parameter int NUM_CH   = 3,
    parameter int TICK_DIV = 12000000,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    led_pattern_gen_if.slave  cfg,
    output logic              tick,
    output logic [NUM_CH-1:0] led
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_PWM     = 2'b01,
        M_BLINK   = 2'b10,
        M_BREATHE = 2'b11
    } mode_e;

    logic [PW-1:0]     pre_q, pre_d;
    logic              tick_q, tick_d;
    logic [7:0]        pwm_q, pwm_d;
    logic [NUM_CH-1:0] led_q, led_d;

    mode_e      mode_q   [NUM_CH];
    mode_e      mode_d   [NUM_CH];
    logic [7:0] param_q  [NUM_CH];
    logic [7:0] param_d  [NUM_CH];
    logic [7:0] tcnt_q   [NUM_CH];
    logic [7:0] tcnt_d   [NUM_CH];
    logic       bstate_q [NUM_CH];
    logic       bstate_d [NUM_CH];
    logic [7:0] duty_q   [NUM_CH];
    logic [7:0] duty_d   [NUM_CH];
    logic       dir_q    [NUM_CH];
    logic       dir_d    [NUM_CH];

    logic [CH_W-1:0] wr_ch;
    logic [8:0]      bsum;

    assign wr_ch = cfg.cfg_ch;

    function automatic logic pwm_on(input logic [7:0] d,
                                    input logic [7:0] c);
        return (d == 8'hFF) || (c < d);
    endfunction

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_q == PRE_LAST);
        pwm_d  = pwm_q + 8'd1;
        led_d  = '0;
        bsum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]   = mode_q[i];
            param_d[i]  = param_q[i];
            tcnt_d[i]   = tcnt_q[i];
            bstate_d[i] = bstate_q[i];
            duty_d[i]   = duty_q[i];
            dir_d[i]    = dir_q[i];

            if (tick_q) begin
                unique case (mode_q[i])
                    M_BLINK: begin
                        if (tcnt_q[i] == param_q[i]) begin
                            bstate_d[i] = ~bstate_q[i];
                            tcnt_d[i]   = '0;
                        end else begin
                            tcnt_d[i] = tcnt_q[i] + 8'd1;
                        end
                    end
                    M_BREATHE: begin
                        bsum = {1'b0, duty_q[i]} + {1'b0, param_q[i]};
                        // dir_q = 1 means ramping down
                        if (!dir_q[i]) begin
                            if (bsum >= 9'd255) begin
                                duty_d[i] = 8'hFF;
                                dir_d[i]  = 1'b1;
                            end else begin
                                duty_d[i] = bsum[7:0];
                            end
                        end else if (duty_q[i] <= param_q[i]) begin
                            duty_d[i] = '0;
                            dir_d[i]  = 1'b0;
                        end else begin
                            duty_d[i] = duty_q[i] - param_q[i];
                        end
                    end
                    default: ;
                endcase
            end

            // A write beats a coincident tick on the same channel
            if (cfg.cfg_we && int'(wr_ch) == i) begin
                mode_d[i]   = mode_e'(cfg.cfg_mode);
                param_d[i]  = cfg.cfg_param;
                tcnt_d[i]   = '0;
                bstate_d[i] = 1'b1;
                duty_d[i]   = '0;
                dir_d[i]    = 1'b0;
            end

            unique case (mode_q[i])
                M_OFF:     led_d[i] = 1'b0;
                M_PWM:     led_d[i] = pwm_on(param_q[i], pwm_q);
                M_BLINK:   led_d[i] = bstate_q[i];
                M_BREATHE: led_d[i] = pwm_on(duty_q[i], pwm_q);
                default:   led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            pwm_q  <= '0;
            led_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= M_OFF;
                param_q[i]  <= '0;
                tcnt_q[i]   <= '0;
                bstate_q[i] <= 1'b1;
                duty_q[i]   <= '0;
                dir_q[i]    <= 1'b0;
            end
        end else begin
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            param_q  <= param_d;
            tcnt_q   <= tcnt_d;
            bstate_q <= bstate_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
        end
    end

    assign tick = tick_q;
    assign led  = led_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a cycle-count based
// reference model, directed scenarios and randomized configuration.
module tb_led_pattern_gen;
    localparam int NCH = 3;
    localparam int TD  = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick;
    logic [NCH-1:0] led;

    led_pattern_gen_if #(.CH_W(CW)) cfg_if ();

    led_pattern_gen #(
        .NUM_CH  (NCH),
        .TICK_DIV(TD),
        .CH_W    (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .cfg  (cfg_if),
        .tick (tick),
        .led  (led)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model: time since reset drives prescaler and PWM counter
    int             n;
    bit             etick;
    bit [NCH-1:0]   eled;
    int             m_mode  [NCH];
    int             m_param [NCH];
    int             m_tcnt  [NCH];
    bit             m_bst   [NCH];
    int             m_duty  [NCH];
    bit             m_down  [NCH];

    function automatic bit pwm_on(int d, int c);
        return (d == 255) || (c < d);
    endfunction

    task automatic model_edge();
        bit [NCH-1:0] nl;
        bit           ten;
        int           pw;
        if (reset) begin
            n     = 0;
            etick = 0;
            eled  = '0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_param[i] = 0; m_tcnt[i] = 0;
                m_bst[i] = 1; m_duty[i] = 0; m_down[i] = 0;
            end
            return;
        end
        pw = n % 256;
        nl = '0;
        for (int i = 0; i < NCH; i++) begin
            case (m_mode[i])
                1: nl[i] = pwm_on(m_param[i], pw);
                2: nl[i] = m_bst[i];
                3: nl[i] = pwm_on(m_duty[i], pw);
                default: nl[i] = 0;
            endcase
        end
        ten = etick;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == i) begin
                m_mode[i] = int'(cfg_if.cfg_mode);
                m_param[i] = int'(cfg_if.cfg_param);
                m_tcnt[i] = 0; m_bst[i] = 1;
                m_duty[i] = 0; m_down[i] = 0;
            end else if (ten && m_mode[i] == 2) begin
                if (m_tcnt[i] == m_param[i]) begin
                    m_bst[i] = !m_bst[i];
                    m_tcnt[i] = 0;
                end else begin
                    m_tcnt[i]++;
                end
            end else if (ten && m_mode[i] == 3) begin
                if (!m_down[i]) begin
                    if (m_duty[i] + m_param[i] >= 255) begin
                        m_duty[i] = 255; m_down[i] = 1;
                    end else begin
                        m_duty[i] += m_param[i];
                    end
                end else if (m_duty[i] <= m_param[i]) begin
                    m_duty[i] = 0; m_down[i] = 0;
                end else begin
                    m_duty[i] -= m_param[i];
                end
            end
        end
        n++;
        etick = (n % TD == 0);
        eled  = nl;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tick", 32'(tick), 32'(etick));
        check("led", 32'(led), 32'(eled));
    endtask

    task automatic wr(int ch, int mode, int param);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_ch    = CW'(ch);
        cfg_if.cfg_mode  = 2'(mode);
        cfg_if.cfg_param = 8'(param);
        step();
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic high_time(int bit_i, output int hi);
        hi = 0;
        repeat (256) begin
            step();
            if (led[bit_i]) hi++;
        end
    endtask

    int k;
    int hi;
    bit seen;

    initial begin
        reset            = 1'b1;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_param = '0;
        step();
        step();
        check("reset_led", 32'(led), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        reset = 1'b0;

        // first tick exactly TD cycles after reset release
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            step(); k++;
            seen = (tick === 1'b1);
        end
        check("first_tick_delay", 32'(k), 32'(TD));
        repeat (16) step();

        wr(0, 2, 1);
        step();
        check("blink_start", 32'(led[0]), 32'd1);
        repeat (32) step();

        wr(1, 1, 64);
        step();
        high_time(1, hi);
        check("pwm64_hi", 32'(hi), 32'd64);
        wr(1, 1, 0);
        step();
        high_time(1, hi);
        check("pwm0_hi", 32'(hi), 32'd0);
        wr(1, 1, 255);
        step();
        high_time(1, hi);
        check("pwm255_hi", 32'(hi), 32'd256);

        wr(2, 3, 100);
        repeat (120) step();

        // out-of-range channel write must be ignored
        wr(3, 1, 255);
        repeat (3) step();

        // ch0 write coinciding with a tick
        k = 0; seen = 0;
        while (!seen && k < 10) begin
            step(); k++;
            seen = (tick === 1'b1);
        end
        check("tick_found", 32'(seen), 32'd1);
        wr(0, 2, 2);
        repeat (30) step();

        // reset in the middle of breathing
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_led", 32'(led), 32'd0);
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            step(); k++;
            seen = (tick === 1'b1);
        end
        check("midreset_tick_delay", 32'(k), 32'(TD));

        repeat (4000) begin
            reset         = ($urandom_range(0, 999) == 0);
            cfg_if.cfg_we = ($urandom_range(0, 15) == 0);
            cfg_if.cfg_ch   = CW'($urandom_range(0, 3));
            cfg_if.cfg_mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: cfg_if.cfg_param = 8'($urandom_range(0, 3));
                1: cfg_if.cfg_param = 8'($urandom_range(0, 255));
                2: cfg_if.cfg_param = 8'($urandom_range(250, 255));
                default: cfg_if.cfg_param = 8'($urandom_range(20, 130));
            endcase
            step();
        end
        reset         = 1'b0;
        cfg_if.cfg_we = 1'b0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end
endmodule
